prbs8_checker: RTL and testbench

- Downstream consumer of the 8-bit LFSR generator. It receives the generator's parallel state word, one word per enable cycle, and self-synchronises to the sequence.
- Once locked, it predicts every following word independently of the input, and it flags and counts mismatches.
- Used for link, loopback and FIFO-path integrity tests. Its locked and error outputs feed the status and debug registers.

---
 rtl/lfsr8_pkg.sv | 18 +
 rtl/sat_counter.sv | 32 +++
 rtl/prbs8_checker.sv | 123 ++++++++++++
 tb/tb_prbs8_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr8_pkg.sv
// Shared definitions for the 8-bit LFSR generator and its checker:
// one polynomial, the lock-up value and the checker's sync states.
package lfsr8_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  localparam logic [7:0] LFSR8_LOCKUP = 8'h00;

  // Must stay bit-exact with the generator's state update.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:4], s[7] ^ s[3], s[7] ^ s[2], s[7] ^ s[1], s[0], s[7]};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;

  // Count register: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/prbs8_checker.sv
// Self-synchronising checker for the 8-bit LFSR state stream: hunts, verifies,
// then free-runs its own prediction and flags/counts mismatching words.
module prbs8_checker
  import lfsr8_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       sync_state
);

  localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CNT - 1);
  localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_CNT - 1);

  sync_state_t state_r;
  logic [7:0]  pred_r;
  logic [3:0]  match_cnt_r;
  logic [3:0]  bad_cnt_r;
  logic        locked_r;
  logic        err_pulse_r;
  logic        err_event_s;

  // A counted error is any valid word that disagrees with the free-running prediction.
  always_comb begin
    err_event_s = 1'b0;
    if (in_valid && (state_r == LOCKED) && (in_data != pred_r)) begin
      err_event_s = 1'b1;
    end else begin
      err_event_s = 1'b0;
    end
  end

  // Sync FSM with its prediction, run-length counters and registered flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= HUNT;
      pred_r      <= 8'h00;
      match_cnt_r <= 4'd0;
      bad_cnt_r   <= 4'd0;
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
    end else begin
      err_pulse_r <= err_event_s;
      if (in_valid) begin
        case (state_r)
          HUNT: begin
            if (in_data != LFSR8_LOCKUP) begin
              pred_r      <= lfsr8_next(in_data);
              match_cnt_r <= 4'd0;
              state_r     <= VERIFY;
            end else begin
              state_r     <= HUNT;
            end
          end
          VERIFY: begin
            if (in_data == pred_r) begin
              pred_r <= lfsr8_next(in_data);
              if (match_cnt_r == LOCK_LAST) begin
                match_cnt_r <= 4'd0;
                bad_cnt_r   <= 4'd0;
                locked_r    <= 1'b1;
                state_r     <= LOCKED;
              end else begin
                match_cnt_r <= match_cnt_r + 4'd1;
              end
            end else if (in_data == LFSR8_LOCKUP) begin
              match_cnt_r <= 4'd0;
              state_r     <= HUNT;
            end else begin
              // Reseed from the new word rather than dropping back to HUNT.
              pred_r      <= lfsr8_next(in_data);
              match_cnt_r <= 4'd0;
            end
          end
          LOCKED: begin
            pred_r <= lfsr8_next(pred_r);
            if (err_event_s) begin
              if (bad_cnt_r == UNLOCK_LAST) begin
                bad_cnt_r <= 4'd0;
                locked_r  <= 1'b0;
                state_r   <= HUNT;
              end else begin
                bad_cnt_r <= bad_cnt_r + 4'd1;
              end
            end else begin
              bad_cnt_r <= 4'd0;
            end
          end
          default: begin
            locked_r <= 1'b0;
            state_r  <= HUNT;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_event_s),
    .clr   (clr_err),
    .count (err_count)
  );

  assign locked     = locked_r;
  assign err_pulse  = err_pulse_r;
  assign sync_state = state_r;

endmodule

// File: tb/tb_prbs8_checker.sv
// Randomized and directed bench for prbs8_checker; two instances (default and
// saturation-test parameters) share stimulus and are compared to a rule model.
module tb_prbs8_checker;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clr_err;
  logic        locked_a, err_pulse_a, locked_b, err_pulse_b;
  logic [15:0] err_count_a;
  logic [3:0]  err_count_b;
  logic [1:0]  sync_state_a, sync_state_b;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state, index 0 = default instance, 1 = saturation instance
  int m_state[2], m_pred[2], m_match[2], m_bad[2], m_err[2], m_locked[2], m_pulse[2];
  int p_lock[2]   = '{4, 4};
  int p_unlock[2] = '{3, 15};
  int p_max[2]    = '{65535, 15};

  logic [7:0] gen, dat;

  prbs8_checker u_dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a), .sync_state(sync_state_a)
  );

  prbs8_checker #(.LOCK_CNT(4), .UNLOCK_CNT(15), .ERR_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b), .sync_state(sync_state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial x^8+x^4+x^3+x^2+1: multiply by x, reduce when the top bit falls out.
  function automatic logic [7:0] nx8(input logic [7:0] s);
    int v;
    v = int'(s) * 2;
    if (v >= 256) v = (v - 256) ^ 29;
    return 8'(v);
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_pred[k] = 0; m_match[k] = 0; m_bad[k] = 0;
      m_err[k] = 0; m_locked[k] = 0; m_pulse[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic v, input logic [7:0] d, input logic c);
    m_pulse[k] = 0;
    if (v) begin
      if (m_state[k] == 0) begin
        if (d != 8'd0) begin
          m_pred[k] = nx8(d); m_match[k] = 0; m_state[k] = 1;
        end
      end else if (m_state[k] == 1) begin
        if (int'(d) == m_pred[k]) begin
          m_pred[k] = nx8(d); m_match[k]++;
          if (m_match[k] == p_lock[k]) begin
            m_state[k] = 2; m_locked[k] = 1; m_bad[k] = 0;
          end
        end else if (d == 8'd0) begin
          m_state[k] = 0;
        end else begin
          m_pred[k] = nx8(d); m_match[k] = 0;
        end
      end else begin
        if (int'(d) != m_pred[k]) begin
          m_pulse[k] = 1;
          if (m_err[k] < p_max[k]) m_err[k]++;
          m_bad[k]++;
          if (m_bad[k] == p_unlock[k]) begin
            m_state[k] = 0; m_locked[k] = 0; m_bad[k] = 0;
          end
        end else begin
          m_bad[k] = 0;
        end
        m_pred[k] = nx8(8'(m_pred[k]));
      end
    end
    if (c) m_err[k] = 0;
  endtask

  task automatic compare_all();
    check_value("a_locked", locked_a, m_locked[0]);
    check_value("a_pulse",  err_pulse_a, m_pulse[0]);
    check_value("a_count",  err_count_a, m_err[0]);
    check_value("a_state",  sync_state_a, m_state[0]);
    check_value("b_locked", locked_b, m_locked[1]);
    check_value("b_pulse",  err_pulse_b, m_pulse[1]);
    check_value("b_count",  err_count_b, m_err[1]);
    check_value("b_state",  sync_state_b, m_state[1]);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic c);
    in_valid = v; in_data = d; clr_err = c;
    @(posedge clk);
    model_step(0, v, d, c);
    model_step(1, v, d, c);
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; clr_err = 1'b0;
    #1;
    check_value("rst_locked", {locked_a, locked_b}, 0);
    check_value("rst_pulse",  {err_pulse_a, err_pulse_b}, 0);
    check_value("rst_count",  {err_count_a, err_count_b}, 0);
    check_value("rst_state",  {sync_state_a, sync_state_b}, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic lock_seq();
    logic [7:0] w;
    w = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, w, 1'b0);
      w = nx8(w);
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; clr_err = 1'b0;
    apply_reset();

    // lock from the generator's reset value
    step(1'b1, 8'h0F, 1'b0);
    check_value("lock_state1", sync_state_a, 1);
    step(1'b1, 8'h1E, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'h78, 1'b0);
    check_value("lock_early", locked_a, 0);
    step(1'b1, 8'hF0, 1'b0);
    check_value("lock_up", locked_a, 1);
    check_value("lock_state2", sync_state_a, 2);
    check_value("lock_count", err_count_a, 0);

    // single corrupted word
    step(1'b1, 8'hFC, 1'b0);
    check_value("single_pulse", err_pulse_a, 1);
    check_value("single_count", err_count_a, 1);
    check_value("single_locked", locked_a, 1);
    step(1'b1, 8'hE7, 1'b0);
    check_value("single_nopulse", err_pulse_a, 0);
    step(1'b1, 8'hD3, 1'b0);
    check_value("single_count2", err_count_a, 1);

    // loss of sync and relock
    apply_reset();
    lock_seq();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h55, 1'b0);
    check_value("unlock_count", err_count_a, 3);
    check_value("unlock_locked", locked_a, 0);
    check_value("unlock_state", sync_state_a, 0);
    lock_seq();
    check_value("relock", locked_a, 1);

    // lock-up words and VERIFY reseed
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h00, 1'b0);
      check_value("lockup_hunt", sync_state_a, 0);
    end
    step(1'b1, 8'h0F, 1'b0);
    step(1'b1, 8'h1E, 1'b0);
    step(1'b1, 8'h99, 1'b0);
    check_value("reseed_state", sync_state_a, 1);
    check_value("reseed_count", err_count_a, 0);
    gen = nx8(8'h99);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, gen, 1'b0);
      gen = nx8(gen);
    end
    check_value("reseed_lock", locked_a, 1);

    // lock sequence with in_valid gaps
    apply_reset();
    gen = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, gen, 1'b0);
      step(1'b0, 8'($urandom_range(255)), 1'b0);
      gen = nx8(gen);
    end
    check_value("gap_lock", locked_a, 1);
    check_value("gap_count", err_count_a, 0);

    // alternating good/bad words: saturation, clear priority, async reset
    apply_reset();
    lock_seq();
    gen = 8'hFD;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, (i % 2 == 1) ? (gen ^ 8'h01) : gen, 1'b0);
      gen = nx8(gen);
    end
    check_value("sat_b", err_count_b, 15);
    check_value("sat_a", err_count_a, 20);
    check_value("sat_locked", locked_b, 1);
    step(1'b1, gen ^ 8'h01, 1'b1);
    gen = nx8(gen);
    check_value("clr_pulse", err_pulse_a, 1);
    check_value("clr_count", err_count_a, 0);
    check_value("clr_count_b", err_count_b, 0);
    apply_reset();

    // randomized traffic with corruption, lock-up words, reseeds and clears
    gen = 8'h0F;
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic v, c;
      v = ($urandom_range(3) != 0);
      r = $urandom_range(63);
      if (r == 0) gen = 8'($urandom_range(255, 1));
      dat = gen;
      if (r >= 1 && r <= 4) dat = gen ^ 8'(1 << $urandom_range(7));
      else if (r == 5) dat = 8'h00;
      c = ($urandom_range(31) == 0);
      step(v, dat, c);
      if (v) gen = nx8(gen);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
